// File: rtl/sram_axi_bridge_mp.sv
// Multi-port sram-like to AXI3 bridge: one registered AR slot, one write slot, per-port IDs.
// Fixed priority (port 0 highest); reads stall behind a pending write to the same word.
module sram_axi_bridge_mp #(
  parameter int unsigned NPORT = 2,
  parameter int unsigned ID_W  = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NPORT-1:0]      req,
  input  logic [NPORT-1:0]      wr,
  input  logic [2*NPORT-1:0]    size,
  input  logic [32*NPORT-1:0]   addr,
  input  logic [32*NPORT-1:0]   wdata,
  input  logic [4*NPORT-1:0]    wstrb_in,
  output logic [32*NPORT-1:0]   rdata_out,
  output logic [NPORT-1:0]      addr_ok,
  output logic [NPORT-1:0]      data_ok,
  output logic [ID_W-1:0]       arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [ID_W-1:0]       rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ID_W-1:0]       awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ID_W-1:0]       wid,
  output logic [31:0]           wdata_o_unused_guard,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [ID_W-1:0]       bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  typedef enum logic [1:0] {StWEmpty, StWIssue, StWResp} wslot_st_e;

  logic [NPORT-1:0] rd_pend_q, wr_pend_q;

  logic             ar_full_q;
  logic [ID_W-1:0]  ar_id_q;
  logic [31:0]      araddr_q;
  logic [2:0]       arsize_q;
  logic             rready_q;

  wslot_st_e        wst_q;
  logic             aw_pend_q, w_pend_q;
  logic [31:0]      awaddr_q, wdata_q;
  logic [3:0]       wstrb_q;
  logic [2:0]       awsize_q;
  logic [ID_W-1:0]  wowner_q;

  logic [NPORT-1:0] rd_win, wr_win, rd_ret, wr_ret;
  logic             rd_found, wr_found, wslot_busy;
  logic [ID_W-1:0]  rd_id, wr_id;
  logic [31:0]      rd_addr, wr_addr, wr_data;
  logic [1:0]       rd_size, wr_size;
  logic [3:0]       wr_strb;

  assign wslot_busy = (wst_q != StWEmpty);

  // Arbitration: first eligible port in index order wins each slot.
  always_comb begin
    rd_win   = '0;
    rd_found = 1'b0;
    rd_id    = '0;
    rd_addr  = '0;
    rd_size  = '0;
    wr_win   = '0;
    wr_found = 1'b0;
    wr_id    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_strb  = '0;
    wr_size  = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      if (!rd_found && resetn && req[p] && !wr[p] && !rd_pend_q[p] && !wr_pend_q[p] &&
          !ar_full_q && !(wslot_busy && addr[32*p+2 +: 30] == awaddr_q[31:2])) begin
        rd_found  = 1'b1;
        rd_win[p] = 1'b1;
        rd_id     = ID_W'(p);
        rd_addr   = addr[32*p +: 32];
        rd_size   = size[2*p +: 2];
      end
      if (!wr_found && resetn && req[p] && wr[p] && !rd_pend_q[p] && !wr_pend_q[p] &&
          !wslot_busy) begin
        wr_found  = 1'b1;
        wr_win[p] = 1'b1;
        wr_id     = ID_W'(p);
        wr_addr   = addr[32*p +: 32];
        wr_data   = wdata[32*p +: 32];
        wr_strb   = wstrb_in[4*p +: 4];
        wr_size   = size[2*p +: 2];
      end
    end
  end

  always_comb begin
    rd_ret    = '0;
    wr_ret    = '0;
    rdata_out = '0;
    for (int unsigned p = 0; p < NPORT; p++) begin
      rd_ret[p] = resetn && rvalid && rready_q && (rid == ID_W'(p)) && rd_pend_q[p];
      wr_ret[p] = resetn && bvalid && (wst_q == StWResp) && (wowner_q == ID_W'(p));
      if (rd_ret[p]) rdata_out[32*p +: 32] = rdata;
    end
  end

  assign addr_ok = rd_win | wr_win;
  assign data_ok = rd_ret | wr_ret;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_pend_q <= '0;
      wr_pend_q <= '0;
      ar_full_q <= 1'b0;
      ar_id_q   <= '0;
      araddr_q  <= '0;
      arsize_q  <= '0;
      rready_q  <= 1'b0;
      wst_q     <= StWEmpty;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awsize_q  <= '0;
      wowner_q  <= '0;
    end else begin
      rready_q  <= 1'b1;
      rd_pend_q <= (rd_pend_q & ~rd_ret) | rd_win;
      wr_pend_q <= (wr_pend_q & ~wr_ret) | wr_win;

      if (ar_full_q) begin
        if (arready) ar_full_q <= 1'b0;
      end else if (rd_found) begin
        ar_full_q <= 1'b1;
        ar_id_q   <= rd_id;
        araddr_q  <= rd_addr;
        arsize_q  <= {1'b0, rd_size};
      end

      case (wst_q)
        StWEmpty: begin
          if (wr_found) begin
            wst_q     <= StWIssue;
            aw_pend_q <= 1'b1;
            w_pend_q  <= 1'b1;
            awaddr_q  <= wr_addr;
            wdata_q   <= wr_data;
            wstrb_q   <= wr_strb;
            awsize_q  <= {1'b0, wr_size};
            wowner_q  <= wr_id;
          end
        end
        StWIssue: begin
          if (awready) aw_pend_q <= 1'b0;
          if (wready) w_pend_q <= 1'b0;
          // AW and W complete independently; response phase starts once both are done.
          if ((!aw_pend_q || awready) && (!w_pend_q || wready)) wst_q <= StWResp;
        end
        StWResp: begin
          if (bvalid) wst_q <= StWEmpty;
        end
        default: wst_q <= StWEmpty;
      endcase
    end
  end

  assign arid    = ar_id_q;
  assign araddr  = araddr_q;
  assign arlen   = 8'd0;
  assign arsize  = arsize_q;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = ar_full_q;
  assign rready  = rready_q;

  assign awid    = wowner_q;
  assign awaddr  = awaddr_q;
  assign awlen   = 8'd0;
  assign awsize  = awsize_q;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = aw_pend_q;

  assign wid                  = wowner_q;
  assign wdata_o_unused_guard = wdata_q;
  assign wstrb                = wstrb_q;
  assign wlast                = 1'b1;
  assign wvalid               = w_pend_q;

  assign bready = (wst_q == StWResp);

  logic unused_resp;
  assign unused_resp = ^{rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge_mp.sv
// Directed bench for sram_axi_bridge_mp (NPORT=2); hand-driven AXI slave responses.
module tb_sram_axi_bridge_mp;

  localparam int unsigned NPORT = 2;
  localparam int unsigned ID_W  = 4;

  logic               clk = 1'b0;
  logic               resetn;
  logic [1:0]         req, wr, addr_ok, data_ok;
  logic [3:0]         size;
  logic [63:0]        addr, wdata, rdata_out;
  logic [7:0]         wstrb_in;
  logic [ID_W-1:0]    arid, rid, awid, wid, bid;
  logic [31:0]        araddr, rdata, awaddr, axi_wdata;
  logic [7:0]         arlen, awlen;
  logic [2:0]         arsize, arprot, awsize, awprot;
  logic [1:0]         arburst, arlock, rresp, awburst, awlock, bresp;
  logic [3:0]         arcache, awcache, wstrb;
  logic               arvalid, arready, rlast, rvalid, rready;
  logic               awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_axi_bridge_mp #(.NPORT(NPORT), .ID_W(ID_W)) dut (
    .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .wstrb_in(wstrb_in), .rdata_out(rdata_out), .addr_ok(addr_ok), .data_ok(data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata_o_unused_guard(axi_wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  // Inputs change just after the falling edge; checks run 1 time unit later.
  task automatic next_cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; req = 2'b00; wr = 2'b00; size = '0; addr = '0; wdata = '0; wstrb_in = '0;
    arready = 0; rid = '0; rdata = '0; rresp = '0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = '0; bresp = '0; bvalid = 0;
    next_cyc(); next_cyc();
    req = 2'b01;
    #1;
    n_cmp++; if ({arvalid, awvalid, wvalid, bready, rready} !== 5'b0) begin
      n_err++; $display("FAIL reset_valids: got %b want 00000", {arvalid, awvalid, wvalid, bready, rready}); end
    n_cmp++; if ({addr_ok, data_ok} !== 4'b0) begin
      n_err++; $display("FAIL reset_ok: got %b want 0000", {addr_ok, data_ok}); end
    n_cmp++; if ({araddr, awaddr, axi_wdata, arid, awid} !== '0) begin
      n_err++; $display("FAIL reset_addr_data: got %h want 0", {araddr, awaddr, axi_wdata}); end
    req = 2'b00; resetn = 1'b1;
    next_cyc(); #1;
    n_cmp++; if (rready !== 1'b1) begin
      n_err++; $display("FAIL rready_after_reset: got %b want 1", rready); end
    n_cmp++; if ({arburst, arlen, wlast} !== {2'b01, 8'd0, 1'b1}) begin
      n_err++; $display("FAIL axi_consts: got %h want 201", {arburst, arlen, wlast}); end
    next_cyc();
  endtask

  task automatic test_read_single();
    req = 2'b10; wr = 2'b00; size[3:2] = 2'd2; addr[63:32] = 32'h100;
    #1;
    n_cmp++; if (addr_ok !== 2'b10) begin
      n_err++; $display("FAIL rd1_addr_ok: got %b want 10", addr_ok); end
    next_cyc(); req = 2'b00; arready = 1; #1;
    n_cmp++; if ({arvalid, arid, araddr, arsize} !== {1'b1, 4'd1, 32'h100, 3'd2}) begin
      n_err++; $display("FAIL rd1_ar: got v%b id%0d a%h s%0d want v1 id1 a100 s2",
                        arvalid, arid, araddr, arsize); end
    next_cyc(); arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'hDEADBEEF; #1;
    n_cmp++; if (arvalid !== 1'b0) begin
      n_err++; $display("FAIL rd1_ar_drop: got %b want 0", arvalid); end
    n_cmp++; if (data_ok !== 2'b10 || rdata_out !== {32'hDEADBEEF, 32'h0}) begin
      n_err++; $display("FAIL rd1_data: got ok%b %h want ok10 deadbeef00000000", data_ok, rdata_out); end
    next_cyc(); rvalid = 0; #1;
    n_cmp++; if (data_ok !== 2'b00 || rdata_out !== 64'h0) begin
      n_err++; $display("FAIL rd1_idle: got ok%b %h want ok00 0", data_ok, rdata_out); end
    next_cyc();
  endtask

  task automatic test_read_two_ports();
    req = 2'b11; wr = 2'b00; size = 4'b1010; addr = {32'h2000, 32'h1000};
    #1;
    n_cmp++; if (addr_ok !== 2'b01) begin
      n_err++; $display("FAIL rd2_prio: got %b want 01", addr_ok); end
    next_cyc(); req = 2'b10; arready = 1; #1;
    n_cmp++; if (addr_ok !== 2'b00 || arid !== 4'd0 || araddr !== 32'h1000) begin
      n_err++; $display("FAIL rd2_ar0: got ok%b id%0d a%h want ok00 id0 a1000", addr_ok, arid, araddr); end
    next_cyc(); arready = 0; #1;
    n_cmp++; if (addr_ok !== 2'b10) begin
      n_err++; $display("FAIL rd2_p1_accept: got %b want 10", addr_ok); end
    next_cyc(); req = 2'b00; arready = 1; #1;
    n_cmp++; if ({arvalid, arid, araddr} !== {1'b1, 4'd1, 32'h2000}) begin
      n_err++; $display("FAIL rd2_ar1: got v%b id%0d a%h want v1 id1 a2000", arvalid, arid, araddr); end
    next_cyc(); arready = 0; rvalid = 1; rid = 4'd1; rdata = 32'h22222222; #1;
    n_cmp++; if (data_ok !== 2'b10 || rdata_out[63:32] !== 32'h22222222) begin
      n_err++; $display("FAIL rd2_ret1: got ok%b %h want ok10 22222222", data_ok, rdata_out[63:32]); end
    next_cyc(); rid = 4'd0; rdata = 32'h11111111; #1;
    n_cmp++; if (data_ok !== 2'b01 || rdata_out !== {32'h0, 32'h11111111}) begin
      n_err++; $display("FAIL rd2_ret0: got ok%b %h want ok01 11111111", data_ok, rdata_out); end
    next_cyc(); rvalid = 0;
    next_cyc();
  endtask

  task automatic test_write_read_parallel();
    req = 2'b11; wr = 2'b01; size = 4'b1001; addr = {32'h300, 32'h200};
    wdata = {32'h0, 32'hA5A51234}; wstrb_in = 8'h03;
    #1;
    n_cmp++; if (addr_ok !== 2'b11) begin
      n_err++; $display("FAIL wr_par_addr_ok: got %b want 11", addr_ok); end
    next_cyc(); req = 2'b00; wdata = '1; wstrb_in = '1; arready = 1; #1;
    n_cmp++; if ({awvalid, wvalid, awid, wid, awaddr, awsize, wstrb} !==
                 {1'b1, 1'b1, 4'd0, 4'd0, 32'h200, 3'd1, 4'b0011}) begin
      n_err++; $display("FAIL wr_par_aw_w: got v%b%b id%0d/%0d a%h s%0d st%b want v11 id0/0 a200 s1 st0011",
                        awvalid, wvalid, awid, wid, awaddr, awsize, wstrb); end
    n_cmp++; if (axi_wdata !== 32'hA5A51234 || arid !== 4'd1 || araddr !== 32'h300) begin
      n_err++; $display("FAIL wr_par_wdata_ar: got wd%h id%0d a%h want wda5a51234 id1 a300",
                        axi_wdata, arid, araddr); end
    next_cyc(); arready = 0; awready = 1; wready = 1; rvalid = 1; rid = 4'd1; rdata = 32'h33333333; #1;
    n_cmp++; if (axi_wdata !== 32'hA5A51234 || data_ok !== 2'b10 || bready !== 1'b0) begin
      n_err++; $display("FAIL wr_par_t2: got wd%h ok%b br%b want wda5a51234 ok10 br0",
                        axi_wdata, data_ok, bready); end
    next_cyc(); awready = 0; wready = 0; rvalid = 0; bvalid = 1; bid = 4'd0; #1;
    n_cmp++; if ({awvalid, wvalid, bready, data_ok} !== 5'b00101) begin
      n_err++; $display("FAIL wr_par_resp: got %b want 00101", {awvalid, wvalid, bready, data_ok}); end
    next_cyc(); bvalid = 0; #1;
    n_cmp++; if (bready !== 1'b0 || data_ok !== 2'b00) begin
      n_err++; $display("FAIL wr_par_done: got br%b ok%b want br0 ok00", bready, data_ok); end
    next_cyc();
  endtask

  task automatic test_hazard();
    req = 2'b10; wr = 2'b10; size = 4'b1001; addr = {32'h40, 32'h42};
    wdata = {32'h12345678, 32'h0}; wstrb_in = 8'hF0;
    #1;
    n_cmp++; if (addr_ok !== 2'b10) begin
      n_err++; $display("FAIL haz_wr_accept: got %b want 10", addr_ok); end
    next_cyc(); req = 2'b01; wr = 2'b00; awready = 1; wready = 1; #1;
    n_cmp++; if (addr_ok !== 2'b00) begin
      n_err++; $display("FAIL haz_block_issue: got %b want 00", addr_ok); end
    next_cyc(); awready = 0; wready = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++; if (addr_ok !== 2'b00 || bready !== 1'b1) begin
        n_err++; $display("FAIL haz_block_resp%0d: got ok%b br%b want ok00 br1", i, addr_ok, bready); end
      next_cyc();
    end
    bvalid = 1; bid = 4'd1; #1;
    n_cmp++; if (data_ok !== 2'b10 || addr_ok !== 2'b00) begin
      n_err++; $display("FAIL haz_bresp: got ok%b aok%b want ok10 aok00", data_ok, addr_ok); end
    next_cyc(); bvalid = 0; #1;
    n_cmp++; if (addr_ok !== 2'b01) begin
      n_err++; $display("FAIL haz_release: got %b want 01", addr_ok); end
    next_cyc(); req = 2'b00; arready = 1; #1;
    n_cmp++; if ({arvalid, arid, araddr, arsize} !== {1'b1, 4'd0, 32'h42, 3'd1}) begin
      n_err++; $display("FAIL haz_ar: got v%b id%0d a%h s%0d want v1 id0 a42 s1",
                        arvalid, arid, araddr, arsize); end
    next_cyc(); arready = 0; rvalid = 1; rid = 4'd0; rdata = 32'h44444444; #1;
    n_cmp++; if (data_ok !== 2'b01 || rdata_out[31:0] !== 32'h44444444) begin
      n_err++; $display("FAIL haz_rd_ret: got ok%b %h want ok01 44444444", data_ok, rdata_out[31:0]); end
    next_cyc(); rvalid = 0;
    next_cyc();
  endtask

  task automatic test_w_before_aw();
    req = 2'b01; wr = 2'b01; size = 4'b0010; addr = {32'h0, 32'h80};
    wdata = {32'h0, 32'hCAFEF00D}; wstrb_in = 8'h0F;
    #1;
    n_cmp++; if (addr_ok !== 2'b01) begin
      n_err++; $display("FAIL wfirst_accept: got %b want 01", addr_ok); end
    next_cyc(); req = 2'b00; wready = 1; #1;
    n_cmp++; if ({awvalid, wvalid} !== 2'b11) begin
      n_err++; $display("FAIL wfirst_both: got %b want 11", {awvalid, wvalid}); end
    next_cyc(); wready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_cmp++; if ({awvalid, wvalid, bready} !== 3'b100) begin
        n_err++; $display("FAIL wfirst_hold%0d: got %b want 100", i, {awvalid, wvalid, bready}); end
      next_cyc();
    end
    awready = 1; #1;
    n_cmp++; if ({awvalid, wvalid, bready} !== 3'b100) begin
      n_err++; $display("FAIL wfirst_aw_hs: got %b want 100", {awvalid, wvalid, bready}); end
    next_cyc(); awready = 0; bvalid = 1; bid = 4'd0; #1;
    n_cmp++; if ({awvalid, bready, data_ok} !== 4'b0101) begin
      n_err++; $display("FAIL wfirst_resp: got %b want 0101", {awvalid, bready, data_ok}); end
    next_cyc(); bvalid = 0;
    next_cyc();
  endtask

  task automatic test_reset_mid();
    req = 2'b11; wr = 2'b10; size = 4'b1010; addr = {32'h600, 32'h500};
    wdata = {32'h66666666, 32'h0}; wstrb_in = 8'hF0;
    #1;
    n_cmp++; if (addr_ok !== 2'b11) begin
      n_err++; $display("FAIL rst_mid_accept: got %b want 11", addr_ok); end
    next_cyc(); req = 2'b00; resetn = 1'b0; #1;
    n_cmp++; if ({arvalid, awvalid} !== 2'b11) begin
      n_err++; $display("FAIL rst_mid_inflight: got %b want 11", {arvalid, awvalid}); end
    next_cyc(); resetn = 1'b1; rvalid = 1; rid = 4'd0; rdata = 32'h55555555; #1;
    n_cmp++; if ({arvalid, awvalid, wvalid, bready, data_ok} !== 6'b0) begin
      n_err++; $display("FAIL rst_mid_cleared: got %b want 000000",
                        {arvalid, awvalid, wvalid, bready, data_ok}); end
    n_cmp++; if ({araddr, awaddr, axi_wdata} !== 96'h0) begin
      n_err++; $display("FAIL rst_mid_regs: got %h want 0", {araddr, awaddr, axi_wdata}); end
    next_cyc(); #1;
    n_cmp++; if (data_ok !== 2'b00 || rdata_out !== 64'h0 || rready !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_stray: got ok%b %h rr%b want ok00 0 rr1", data_ok, rdata_out, rready); end
    next_cyc(); rvalid = 0;
    next_cyc();
  endtask

  initial begin
    test_reset();
    test_read_single();
    test_read_two_ports();
    test_write_read_parallel();
    test_hazard();
    test_w_before_aw();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_axi_bridge_mp.md
# sram_axi_bridge_mp

Parametrised multi-port sram-like to AXI3 bridge. It connects NPORT sram-like masters (instruction fetch, data, and future ports such as a TLB walker) to a single AXI master interface. Per-port AXI IDs let reads from different ports be outstanding at the same time, and a write slot runs concurrently with reads. Fixed-priority arbitration applies, and a read-after-write hazard check orders reads behind a pending write to the same word.

## Interface
- NPORT, 2, number of sram-like ports (1..4); port 0 has the highest priority
- ID_W, 4, AXI ID width (must satisfy 2^ID_W >= NPORT)
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- req  in  NPORT  per-port request
- wr  in  NPORT  per-port write (1) or read (0)
- size  in  2*NPORT  per-port size: 0=byte, 1=half, 2=word; port p uses bits [2p+1:2p]
- addr  in  32*NPORT  per-port byte address
- wdata  in  32*NPORT  per-port write data
- wstrb_in  in  4*NPORT  per-port byte enables
- rdata_out  out  32*NPORT  per-port read data, valid only with data_ok
- addr_ok  out  NPORT  request accepted (1-cycle pulse)
- data_ok  out  NPORT  read data returned or write response received (1-cycle pulse)
- AXI ar: arid[ID_W], araddr[32], arlen[8]=0, arsize[3], arburst[2]=01, arlock[2]=0, arcache[4]=0, arprot[3]=0, arvalid out; arready in
- AXI r: rid[ID_W], rdata[32], rresp[2], rlast, rvalid in; rready out
- AXI aw: awid[ID_W], awaddr[32], awlen[8]=0, awsize[3], awburst[2]=01, awlock[2]=0, awcache[4]=0, awprot[3]=0, awvalid out; awready in
- AXI w: wid[ID_W], wdata[32], wstrb[4], wlast=1, wvalid out; wready in
- AXI b: bid[ID_W], bresp[2], bvalid in; bready out

## Operation
- Per-port state:
  - IDLE -> RD_PEND on read acceptance; RD_PEND -> IDLE on rvalid with rid==p.
  - IDLE -> WR_PEND on write acceptance; WR_PEND -> IDLE on bvalid&bready.
  - A port accepts no new request while it is pending.
- AR slot (one entry, registered):
  - EMPTY -> FULL on read acceptance; FULL -> EMPTY on arvalid&arready.
  - arvalid = FULL. araddr, arsize and arid=p stay stable while FULL.
- Read acceptance:
  - The winner is the lowest-index port p with req&~wr, state IDLE, AR slot EMPTY and no hazard.
  - addr_ok[p]=1 combinationally in that cycle.
- Hazard: a read whose addr[31:2] equals the write-slot address [31:2] while the write slot is busy is not accepted until the slot frees.
- Write slot:
  - States: EMPTY -> ISSUE -> RESP -> EMPTY.
  - Accepts the lowest-index port with req&wr, state IDLE, slot EMPTY; addr_ok[p]=1 that cycle.
  - On acceptance it captures addr, wdata, wstrb, size and owner p.
  - ISSUE: awvalid and wvalid rise together. Each drops independently after its own handshake. When both are done, go to RESP.
  - RESP: bready=1. On bvalid: data_ok[owner]=1, then EMPTY.
  - awid = wid = owner.
- Read return:
  - rready=1 at all times out of reset.
  - rvalid with rid=p and port p in RD_PEND: data_ok[p]=1 and rdata_out[p]=rdata.
  - rvalid with an rid that matches no pending port is consumed and ignored.
- Read and write acceptance can occur in the same cycle for different ports.
- rresp and bresp are ignored; rlast is assumed to be 1.
- rdata_out[p] = 0 when data_ok[p] is not asserted.
- Size mapping: arsize/awsize = {1'b0, size}.
- Reset: all valid/ready outputs are 0, addr_ok and data_ok are 0, all address/data/ID outputs are 0, and all states are IDLE/EMPTY. Asserting reset mid-transaction drops all in-flight state without waiting for AXI responses.

## Timing
- Read, best case: addr_ok at T; arvalid at T+1; arready at T+1; rvalid at T+2 gives data_ok at T+2.
- The AR slot can accept the next read at T+2, the cycle after the arready handshake.
- Write, best case: addr_ok at T; awvalid and wvalid at T+1; both ready at T+1; bready at T+2; bvalid at T+2 gives data_ok at T+2.
- The write slot can accept a new write at T+3.
- addr_ok and data_ok are never asserted for the same port in the same cycle.
- rvalid and bvalid for different ports in the same cycle both raise data_ok in that cycle.
- awready arriving before wready (or the reverse): awvalid deasserts the cycle after its handshake while wvalid holds, and the reverse also holds.

## Test plan
- Read, port 1 only, addr 0x100, arready immediate, rdata 0xDEADBEEF one cycle later -> addr_ok[1] at T, arid=1, araddr=0x100, arsize=2, data_ok[1] with rdata_out[1]=0xDEADBEEF at T+2.
- Ports 0 and 1 both request reads at T -> port 0 is accepted at T and port 1 at T+2. Slave returns rid=1 before rid=0 -> data_ok[1] asserts before data_ok[0], each with the correct data.
- Port 0 writes 0x200 with wstrb=0011 and size=1 while port 1 reads 0x300 in the same cycle -> both addr_ok asserted. AW/W carry awid=0, awsize=1, wstrb=0011, wdata held stable. The read proceeds in parallel.
- Port 1 writes 0x40 and port 0 reads 0x42 one cycle later, with bvalid delayed 5 cycles -> the read is held with no addr_ok[0]. The read is accepted the cycle after the write slot frees.
- wready arrives 3 cycles before awready -> wvalid drops after its handshake, awvalid holds until awready, and bready rises only after both handshakes.
- resetn low for 1 cycle while a read and a write are pending -> next cycle all valids and data_ok are 0. A stray rvalid with rid=0 after reset produces no data_ok.
